vector_sequencer: RTL and testbench
===================================

VECTOR_SEQUENCER -- requirements
Module: vector_sequencer

Interface
REQ-001 SHALL have ports: clk in 1 clock; n_reset in 1 reset, asynchronous, active-low.
REQ-002 SHALL have inputs: start 1 (begin op); vs1_base, vs2_base, vd_base 5 each (register group bases); vl 5 (element count); vsew 2 (00=8b, 01=16b, 10=32b); vlmul 2 (group of 1/2/4/8 regs); reduction 1; widening 1.
REQ-003 SHALL have outputs: busy 1; done 1 (one-cycle pulse); vs1_addr, vs2_addr, vd_addr 5 each; reg_write 1; write_elems 5 (valid elements this beat); write_hi 1 (upper widened half); pe_ripple_inputs 1.

Function
REQ-004 SHALL implement FSM with states IDLE, READ, WRITE, DONE.
REQ-005 SHALL accept start only in IDLE, latching all operand inputs that cycle; start outside IDLE is ignored.
REQ-006 SHALL move IDLE->READ on accepted start with vl!=0, and IDLE->DONE with vl==0, issuing no reg_write.
REQ-007 SHALL drive elements-per-beat EPB = 16>>vsew; vsew=11 treated as 10.
REQ-008 SHALL run beats = min(ceil(vl/EPB), 2^vlmul); each beat is one READ cycle then one WRITE cycle.
REQ-009 In READ, SHALL drive vs1_addr=vs1_base+k, vs2_addr=vs2_base+k (k = beat index, modulo 32 wrap).
REQ-010 In WRITE, SHALL assert reg_write for exactly one cycle with vd_addr=vd_base+k and write_elems=min(remaining, EPB).
REQ-011 SHALL go WRITE->READ if beats remain, else WRITE->DONE; DONE pulses done and returns to IDLE next cycle.
REQ-012 busy SHALL be 1 in READ, WRITE, DONE and 0 in IDLE.
REQ-013 Reduction: pe_ripple_inputs=1 throughout op; every WRITE targets vd_base with write_elems=1; beats k>0 read vs1_addr=vd_base.
REQ-014 Address/count outputs SHALL be 0 when not in READ/WRITE.

Reset
REQ-015 n_reset low SHALL force IDLE immediately, all outputs 0, beat counter 0, latched operands 0.
REQ-016 Reset mid-operation SHALL abandon the op with no further reg_write and no done pulse.

Configuration
REQ-017 With VSEQ_WIDENING_EN defined, widening=1 (non-reduction) SHALL produce two WRITE cycles per beat: vd_addr=vd_base+2k with write_hi=0, then vd_base+2k+1 with write_hi=1; EPB uses source vsew; beats capped at 2^vlmul.
REQ-018 Without VSEQ_WIDENING_EN, widening input SHALL be ignored and write_hi tied 0.

Structure
REQ-019 State enum type and EPB lookup SHALL live in accelerator_pkg.
REQ-020 SHALL be one module with no sub-modules; beat/element counters are internal registers.

Verification
REQ-021 vsew=10, vl=10, vlmul=2, bases 4/8/12, start -> 3 writes to vd 12,13,14 with write_elems 4,4,2, then done; 7 cycles start-to-done.
REQ-022 vsew=00, vl=31, vlmul=0 -> single write, vd=vd_base, write_elems=16 (group cap).
REQ-023 vl=0 start -> done pulse next cycle, reg_write never asserted.
REQ-024 reduction=1, vsew=10, vl=8, vd_base=3 -> 2 writes to vd 3, write_elems=1, second READ vs1_addr=3, pe_ripple_inputs high throughout.
REQ-025 vd_base=31, vlmul=1, vl=8, vsew=10 -> writes to vd 31 then 0 (wrap).
REQ-026 n_reset low during second WRITE -> outputs 0 at once, no done; start after release accepted normally.

Source files
------------

// File: rtl/accelerator_pkg.sv
// Shared types and helpers for the vector sequencer.
// Holds the FSM state enum, element-width normalisation and the EPB / beat-count lookups.
// Pure combinational helpers: no latency, no flow control.
package accelerator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } vseq_state_e;

  // The reserved width encoding 11 runs as 32-bit elements.
  function automatic logic [1:0] norm_sew(input logic [1:0] vsew);
    return (vsew == 2'b11) ? 2'b10 : vsew;
  endfunction

  // Elements per beat: 16 >> sew.
  function automatic logic [4:0] epb_lookup(input logic [1:0] sew_n);
    logic [4:0] epb;
    case (sew_n)
      2'b00:   epb = 5'd16;
      2'b01:   epb = 5'd8;
      default: epb = 5'd4;
    endcase
    return epb;
  endfunction

  // Beats = min(ceil(vl / EPB), 2^vlmul). A zero vl gives zero beats.
  function automatic logic [3:0] beat_count(input logic [4:0] vl,
                                            input logic [1:0] sew_n,
                                            input logic [1:0] vlmul);
    logic [5:0] sum;
    logic [5:0] need;
    logic [3:0] cap;
    sum = {1'b0, vl} + {1'b0, epb_lookup(sew_n)} - 6'd1;
    case (sew_n)
      2'b00:   need = sum >> 4;
      2'b01:   need = sum >> 3;
      default: need = sum >> 2;
    endcase
    cap = 4'd1 << vlmul;
    if (need > {2'b00, cap}) begin
      return cap;
    end
    return need[3:0];
  endfunction

endpackage

// File: rtl/vector_sequencer.sv
// Vector register-file sequencer: walks register groups beat by beat (READ then WRITE), then pulses done.
// Latency: one READ + one WRITE cycle per beat (two WRITEs per beat when widening), plus one DONE cycle.
// No backpressure: start is only sampled in IDLE and ignored otherwise. Optional widening: VSEQ_WIDENING_EN.
module vector_sequencer (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       start,
  input  logic [4:0] vs1_base,
  input  logic [4:0] vs2_base,
  input  logic [4:0] vd_base,
  input  logic [4:0] vl,
  input  logic [1:0] vsew,
  input  logic [1:0] vlmul,
  input  logic       reduction,
  input  logic       widening,
  output logic       busy,
  output logic       done,
  output logic [4:0] vs1_addr,
  output logic [4:0] vs2_addr,
  output logic [4:0] vd_addr,
  output logic       reg_write,
  output logic [4:0] write_elems,
  output logic       write_hi,
  output logic       pe_ripple_inputs
);
  import accelerator_pkg::*;

  vseq_state_e state_q;
  logic [4:0]  vs1_base_q;
  logic [4:0]  vs2_base_q;
  logic [4:0]  vd_base_q;
  logic [4:0]  rem_q;      // elements not yet written, counts down by EPB per beat
  logic [1:0]  sew_q;      // normalised element width
  logic [3:0]  beats_q;    // total beats for this op
  logic [3:0]  beat_q;     // current beat index k
  logic        red_q;
  logic        wide_q;     // widening active for this op
  logic        hi_q;       // currently on the upper widened half

  logic [4:0]  epb;
  logic [4:0]  rem_next;
  logic        last_beat;
  logic        more_halves;

  assign epb         = epb_lookup(sew_q);
  assign rem_next    = (rem_q > epb) ? (rem_q - epb) : 5'd0;
  assign last_beat   = (beat_q == (beats_q - 4'd1));
  assign more_halves = wide_q & ~hi_q;

  // Main FSM, operand latch and beat/element counters.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= ST_IDLE;
      vs1_base_q <= 5'd0;
      vs2_base_q <= 5'd0;
      vd_base_q  <= 5'd0;
      rem_q      <= 5'd0;
      sew_q      <= 2'd0;
      beats_q    <= 4'd0;
      beat_q     <= 4'd0;
      red_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            vs1_base_q <= vs1_base;
            vs2_base_q <= vs2_base;
            vd_base_q  <= vd_base;
            rem_q      <= vl;
            sew_q      <= norm_sew(vsew);
            beats_q    <= beat_count(vl, norm_sew(vsew), vlmul);
            beat_q     <= 4'd0;
            red_q      <= reduction;
            state_q    <= (vl == 5'd0) ? ST_DONE : ST_READ;
          end
        end
        ST_READ: begin
          state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          // A pending upper half keeps us in WRITE for one more cycle.
          if (!more_halves) begin
            if (last_beat) begin
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_READ;
              beat_q  <= beat_q + 4'd1;
              rem_q   <= rem_next;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef VSEQ_WIDENING_EN
  // Widening half tracker: lower half first, then upper half of the same beat.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wide_q <= 1'b0;
      hi_q   <= 1'b0;
    end else if ((state_q == ST_IDLE) && start) begin
      wide_q <= widening & ~reduction;
      hi_q   <= 1'b0;
    end else if (state_q == ST_WRITE) begin
      hi_q   <= wide_q & ~hi_q;
    end
  end
`else
  logic unused_widening;
  assign unused_widening = widening;
  assign wide_q = 1'b0;
  assign hi_q   = 1'b0;
`endif

  // Output decode from state and counters; everything idles at zero outside READ/WRITE.
  always_comb begin
    busy             = (state_q != ST_IDLE);
    done             = (state_q == ST_DONE);
    pe_ripple_inputs = (state_q != ST_IDLE) & red_q;
    vs1_addr         = 5'd0;
    vs2_addr         = 5'd0;
    vd_addr          = 5'd0;
    reg_write        = 1'b0;
    write_elems      = 5'd0;
    write_hi         = 1'b0;
    case (state_q)
      ST_READ: begin
        // Reductions feed the running accumulator back in on every beat after the first.
        vs1_addr = (red_q && (beat_q != 4'd0)) ? vd_base_q : (vs1_base_q + {1'b0, beat_q});
        vs2_addr = vs2_base_q + {1'b0, beat_q};
      end
      ST_WRITE: begin
        reg_write   = 1'b1;
        write_hi    = hi_q;
        write_elems = red_q ? 5'd1 : ((rem_q < epb) ? rem_q : epb);
        if (red_q) begin
          vd_addr = vd_base_q;
        end else if (wide_q) begin
          vd_addr = vd_base_q + {beat_q, 1'b0} + {4'd0, hi_q};
        end else begin
          vd_addr = vd_base_q + {1'b0, beat_q};
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_vector_sequencer.sv
// Self-checking bench for vector_sequencer: queue-based reference model compared every cycle,
// directed scenarios with hand-computed expectations, then randomized stimulus with rare resets.
module tb_vector_sequencer;

  logic       clk;
  logic       n_reset;
  logic       start;
  logic [4:0] vs1_base, vs2_base, vd_base, vl;
  logic [1:0] vsew, vlmul;
  logic       reduction, widening;
  logic       busy, done, reg_write, write_hi, pe_ripple_inputs;
  logic [4:0] vs1_addr, vs2_addr, vd_addr, write_elems;

  vector_sequencer dut (
    .clk(clk), .n_reset(n_reset), .start(start),
    .vs1_base(vs1_base), .vs2_base(vs2_base), .vd_base(vd_base), .vl(vl),
    .vsew(vsew), .vlmul(vlmul), .reduction(reduction), .widening(widening),
    .busy(busy), .done(done), .vs1_addr(vs1_addr), .vs2_addr(vs2_addr),
    .vd_addr(vd_addr), .reg_write(reg_write), .write_elems(write_elems),
    .write_hi(write_hi), .pe_ripple_inputs(pe_ripple_inputs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [4:0] vs1;
    logic [4:0] vs2;
    logic [4:0] vd;
    logic       wr;
    logic [4:0] we;
    logic       whi;
    logic       rip;
  } obs_t;

  obs_t act;
  obs_t cur;
  obs_t q[$];
  int   errors = 0;
  int   checks = 0;

  assign act = {busy, done, vs1_addr, vs2_addr, vd_addr, reg_write, write_elems, write_hi, pe_ripple_inputs};

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: expand one accepted operation into the per-cycle outputs it must produce.
  task automatic build(input logic [4:0] b1, input logic [4:0] b2, input logic [4:0] bd,
                       input logic [4:0] n, input logic [1:0] sew, input logic [1:0] lmul,
                       input logic red, input logic wide);
    int   e, nb, rem, halves;
    obs_t r;
    e  = 16 >> ((sew == 2'd3) ? 2 : int'(sew));
    nb = (int'(n) + e - 1) / e;
    if (nb > (1 << lmul)) nb = 1 << lmul;
`ifdef VSEQ_WIDENING_EN
    halves = (wide && !red) ? 2 : 1;
`else
    halves = (wide && 1'b0) ? 2 : 1;
`endif
    for (int k = 0; k < nb; k++) begin
      rem   = int'(n) - k * e;
      r     = '0;
      r.busy = 1'b1;
      r.rip  = red;
      r.vs1  = (red && k > 0) ? bd : 5'(int'(b1) + k);
      r.vs2  = 5'(int'(b2) + k);
      q.push_back(r);
      for (int h = 0; h < halves; h++) begin
        r      = '0;
        r.busy = 1'b1;
        r.rip  = red;
        r.wr   = 1'b1;
        r.we   = red ? 5'd1 : 5'((rem < e) ? rem : e);
        r.whi  = (h == 1);
        if (red)              r.vd = bd;
        else if (halves == 2) r.vd = 5'(int'(bd) + 2 * k + h);
        else                  r.vd = 5'(int'(bd) + k);
        q.push_back(r);
      end
    end
    r      = '0;
    r.busy = 1'b1;
    r.done = 1'b1;
    r.rip  = red;
    q.push_back(r);
  endtask

  // Model advance on every clock edge.
  always @(posedge clk) begin
    if (!n_reset) begin
      q.delete();
      cur = '0;
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else if (!cur.busy && start) begin
      build(vs1_base, vs2_base, vd_base, vl, vsew, vlmul, reduction, widening);
      cur = q.pop_front();
    end else begin
      cur = '0;
    end
  end

  always @(negedge n_reset) begin
    q.delete();
    cur = '0;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    check("cycle_outputs", longint'(act), longint'(cur));
  end

  // Transaction logs for the directed scenarios.
  logic [9:0] wlog[$];
  logic [4:0] rlog[$];
  int         rip_cnt;
  always @(negedge clk) begin
    if (n_reset) begin
      if (reg_write) wlog.push_back({vd_addr, write_elems});
      else if (busy && !done) rlog.push_back(vs1_addr);
      if (pe_ripple_inputs) rip_cnt++;
    end
  end

  function automatic logic [9:0] wl(input int i);
    return (i < wlog.size()) ? wlog[i] : 10'h3ff;
  endfunction
  function automatic logic [4:0] rl(input int i);
    return (i < rlog.size()) ? rlog[i] : 5'h1f;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [4:0] b1, input logic [4:0] b2, input logic [4:0] bd,
                         input logic [4:0] n, input logic [1:0] sew, input logic [1:0] lmul,
                         input logic red, input logic wide);
    vs1_base = b1; vs2_base = b2; vd_base = bd; vl = n;
    vsew = sew; vlmul = lmul; reduction = red; widening = wide;
  endtask

  // Issue one start, wait (bounded) for done, return start-to-done cycle count.
  task automatic run_op(input logic [4:0] b1, input logic [4:0] b2, input logic [4:0] bd,
                        input logic [4:0] n, input logic [1:0] sew, input logic [1:0] lmul,
                        input logic red, input logic wide, output int cycles);
    logic got;
    wlog.delete();
    rlog.delete();
    rip_cnt = 0;
    set_ops(b1, b2, bd, n, sew, lmul, red, wide);
    start = 1'b1;
    tick();
    start  = 1'b0;
    cycles = 1;
    got    = 1'b0;
    while (cycles < 60) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      tick();
      cycles++;
    end
    if (!got) check("done_timeout", 0, 1);
    tick();
  endtask

  int cyc;

  initial begin
    n_reset = 1'b0;
    start   = 1'b0;
    set_ops(5'd0, 5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    repeat (3) tick();
    check("reset_busy", busy, 0);
    check("reset_outputs", longint'(act), 0);
    n_reset = 1'b1;
    tick();

    // 32-bit elements, 10 elements, group of 4: three beats 4,4,2.
    run_op(5'd4, 5'd8, 5'd12, 5'd10, 2'd2, 2'd2, 1'b0, 1'b0, cyc);
    check("basic_cycles", cyc, 7);
    check("basic_nwrites", wlog.size(), 3);
    check("basic_w0", wl(0), {5'd12, 5'd4});
    check("basic_w1", wl(1), {5'd13, 5'd4});
    check("basic_w2", wl(2), {5'd14, 5'd2});
    check("basic_r2_vs1", rl(2), 6);

    // 8-bit elements capped by a single-register group.
    run_op(5'd1, 5'd2, 5'd5, 5'd31, 2'd0, 2'd0, 1'b0, 1'b0, cyc);
    check("cap_nwrites", wlog.size(), 1);
    check("cap_w0", wl(0), {5'd5, 5'd16});

    // Empty vector: straight to done.
    run_op(5'd1, 5'd2, 5'd5, 5'd0, 2'd0, 2'd3, 1'b0, 1'b0, cyc);
    check("vl0_cycles", cyc, 1);
    check("vl0_nwrites", wlog.size(), 0);

    // Reduction over two beats.
    run_op(5'd7, 5'd9, 5'd3, 5'd8, 2'd2, 2'd2, 1'b1, 1'b0, cyc);
    check("red_nwrites", wlog.size(), 2);
    check("red_w0", wl(0), {5'd3, 5'd1});
    check("red_w1", wl(1), {5'd3, 5'd1});
    check("red_r0_vs1", rl(0), 7);
    check("red_r1_vs1", rl(1), 3);
    check("red_ripple_cycles", rip_cnt, 5);

    // Destination wrap past register 31; reserved sew 11 behaves like 32-bit.
    run_op(5'd0, 5'd0, 5'd31, 5'd8, 2'd3, 2'd1, 1'b0, 1'b0, cyc);
    check("wrap_nwrites", wlog.size(), 2);
    check("wrap_w0", wl(0), {5'd31, 5'd4});
    check("wrap_w1", wl(1), {5'd0, 5'd4});

    // Widening request: 16-bit source, 10 elements, 2-register group.
    run_op(5'd0, 5'd0, 5'd4, 5'd10, 2'd1, 2'd1, 1'b0, 1'b1, cyc);
`ifdef VSEQ_WIDENING_EN
    check("wide_nwrites", wlog.size(), 4);
    check("wide_w0", wl(0), {5'd4, 5'd8});
    check("wide_w1", wl(1), {5'd5, 5'd8});
    check("wide_w2", wl(2), {5'd6, 5'd2});
    check("wide_w3", wl(3), {5'd7, 5'd2});
`else
    check("wide_off_nwrites", wlog.size(), 2);
    check("wide_off_w0", wl(0), {5'd4, 5'd8});
    check("wide_off_w1", wl(1), {5'd5, 5'd2});
`endif

    // Reset in the middle of the second WRITE.
    set_ops(5'd4, 5'd8, 5'd12, 5'd10, 2'd2, 2'd2, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("midreset_pre_write", reg_write, 1);
    check("midreset_pre_vd", vd_addr, 13);
    #2;
    n_reset = 1'b0;
    #1;
    check("midreset_outputs_zero", longint'(act), 0);
    repeat (3) tick();
    check("midreset_idle", busy, 0);
    n_reset = 1'b1;
    tick();
    run_op(5'd4, 5'd8, 5'd12, 5'd10, 2'd2, 2'd2, 1'b0, 1'b0, cyc);
    check("after_reset_cycles", cyc, 7);
    check("after_reset_nwrites", wlog.size(), 3);

    // Randomized traffic: random operands every cycle, start often (also while busy), rare resets.
    for (int i = 0; i < 1500; i++) begin
      set_ops(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
              2'($urandom), 2'($urandom), 1'($urandom % 4 == 0), 1'($urandom));
      start   = ($urandom % 3 == 0);
      n_reset = ($urandom % 200 != 0);
      tick();
    end
    n_reset = 1'b1;
    start   = 1'b0;
    repeat (40) tick();
    check("final_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
